// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS sequencer.
// The optional bne support is selected with the MC_BNE_EN macro.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop and the R-type funct field
// onto the 3-bit ALU operation select.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown funct codes fall back to add; the writeback still happens.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore sequencer stepping one MIPS instruction through the
// multicycle datapath. Define MC_BNE_EN to add bne decoding.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  statetype state;
  statetype state_n;
  aluop_t   aluop;
  logic     pcwrite;
  logic     branch;
  logic     mw_raw;
  logic     irw_raw;
  logic     rw_raw;
  logic     take;

  // State register; reset restarts at FETCH and abandons any instruction.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

`ifdef MC_BNE_EN
  logic isbne;

  // Remember in DECODE whether the branch condition must be inverted.
  always_ff @(posedge clk) begin
    if (reset)                 isbne <= 1'b0;
    else if (state == DECODE)  isbne <= (op == OP_BNE);
  end

  assign take = zero ^ isbne;
`else
  assign take = zero;
`endif

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH: state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = RTYPEEX;
          OP_BEQ:       state_n = BEQEX;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_n = BEQEX;
`else
          OP_BNE:       state_n = FETCH;
`endif
          default:      state_n = FETCH;
        endcase
      end
      MEMADR:  state_n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_n = MEMWB;
      RTYPEEX: state_n = RTYPEWB;
      ADDIEX:  state_n = ADDIWB;
      default: state_n = FETCH;
    endcase
  end

  // Per-state control word; anything not set stays deasserted.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    mw_raw   = 1'b0;
    irw_raw  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    rw_raw   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    case (state)
      FETCH: begin
        irw_raw = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        rw_raw   = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        mw_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        rw_raw = 1'b1;
      end
      ADDIWB: rw_raw = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen     = ~reset & (pcwrite | (branch & take));
  assign memwrite = ~reset & mw_raw;
  assign irwrite  = ~reset & irw_raw;
  assign regwrite = ~reset & rw_raw;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencer for the MIPS core's multicycle datapath. It replaces the single-cycle combinational controller with a Moore FSM plus an ALU decoder. One instruction is stepped through fetch, decode, execute, memory and writeback over 3–5 cycles, and the block drives every datapath select and write enable each cycle. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write
- irwrite  out  1  instruction register load
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  write data: 0 = ALUOut, 1 = memory data register
- regwrite  out  1  register file write
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op: lw(100011)/sw(101011)→MEMADR; 000000→RTYPEEX; beq(000100)→BEQEX; addi(001000)→ADDIEX; j(000010)→JEX; any other op→FETCH (executes as a nop).
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB; RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX→FETCH.
- Outputs per state. Signals not listed are 0; aluop selects add unless stated.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, pcsrc=00.
  - DECODE: alusrcb=11 (branch target precomputed into ALUOut).
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=funct-decoded.
  - RTYPEWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BEQEX: alusrca=1, aluop=sub, pcsrc=01, branch=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero).
- ALU decoder:
  - aluop add → 010; aluop sub → 110.
  - funct-decoded: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010, and the writeback still occurs.

## Timing
- State register updates on the rising clk edge. All outputs except pcen are pure functions of the current state. pcen additionally depends combinationally on zero.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- Reset:
  - While reset=1, pcen, memwrite, irwrite and regwrite are forced to 0 regardless of state.
  - At the first edge with reset=1, the state becomes FETCH.
  - Reset mid-instruction abandons it; no partial write occurs after the reset edge.
- After reset deasserts, the first cycle is FETCH with irwrite=1 and pcen=1.
- op and funct are sampled only in DECODE, MEMADR and RTYPEEX. The IR is stable in those states because irwrite=0.
- beq not taken (zero=0 in BEQEX): pcen=0, and the PC keeps PC+4 written in FETCH.

## Configuration
- MC_BNE_EN defined:
  - bne (op 000101) decodes in DECODE to BEQEX.
  - A registered flag captured in DECODE inverts the branch condition: pcen = pcwrite | (branch & (zero ^ isbne)).
  - bne takes 3 cycles.
- MC_BNE_EN undefined: op 000101 is an unknown op (DECODE→FETCH, no PC change beyond +4).

## Structure
- Shared package mc_pkg holds:
  - the state enum `statetype`;
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE;
  - the 2-bit aluop enum;
  - the 3-bit alucontrol constants.
- One sub-module, mc_aludec (aluop, funct → alucontrol). The FSM (mc_controller top) instantiates it.

## Test plan
- Reset held 2 cycles, then released → first cycle: FETCH outputs irwrite=1, pcen=1, alusrcb=01; no write enables active during reset.
- op=100011 (lw) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
- op=000000, funct=101010 → alucontrol=111 in RTYPEEX; regdst=1, regwrite=1 in RTYPEWB; back in FETCH on cycle 5.
- op=000100 with zero=1, then again with zero=0 → pcen=1, pcsrc=01 in BEQEX for the first; pcen=0 for the second.
- op=101011 (sw) with reset asserted in MEMADR → memwrite never goes high; state is FETCH after the reset edge.
- op=000101 → with MC_BNE_EN and zero=0: pcen=1 in cycle 3. Without the macro: FETCH on cycle 3, pcen=0 in cycle 2.
